// File: rtl/digit_box_locator.sv
// digit_box_locator
// Loads per-digit bounding boxes from the column/row border RAMs once
// projection finishes, then classifies each incoming pixel against them.
// Border RAM layout: digit k has its low edge at address 2k+1 and its high
// edge at 2k+2. RAM reads take one cycle.
module digit_box_locator #(
    parameter int NUM_ROW = 1,
    parameter int NUM_COL = 4,
    parameter int DEPBIT  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              project_done_flag,
    input  logic [3:0]        num_col,
    input  logic [3:0]        num_row,
    output logic [DEPBIT-1:0] col_border_addr_rd,
    input  logic [DEPBIT-1:0] col_border_data_rd,
    output logic [DEPBIT-1:0] row_border_addr_rd,
    input  logic [DEPBIT-1:0] row_border_data_rd,
    input  logic              frame_de,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    output logic              boxes_valid,
    output logic              load_busy,
    output logic              cnt_ovf,
    output logic              pix_de,
    output logic              pix_in_box,
    output logic              pix_on_edge,
    output logic [3:0]        box_col_idx,
    output logic [3:0]        box_row_idx
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_COL = 2'd1,
        LOAD_ROW = 2'd2,
        ACTIVE   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic              pdf_r;
    logic              trig_s;
    logic              latch_s;
    logic              done_s;
    logic              cls_en_s;
    logic              ovf_s;
    logic [3:0]        nc_r;
    logic [3:0]        nr_r;
    logic [3:0]        nc_s;
    logic [3:0]        nr_s;
    logic [5:0]        cnt_r;
    logic [5:0]        cnt_nx_s;
    logic [5:0]        lim_s;
    logic [5:0]        addr_nx_s;
    logic [5:0]        cap_idx_s;
    logic [DEPBIT-1:0] col_addr_nx_s;
    logic [DEPBIT-1:0] row_addr_nx_s;

    logic [DEPBIT-1:0] left_r   [NUM_COL];
    logic [DEPBIT-1:0] right_r  [NUM_COL];
    logic [DEPBIT-1:0] top_r    [NUM_ROW];
    logic [DEPBIT-1:0] bottom_r [NUM_ROW];

    logic [NUM_COL-1:0] col_en_s;
    logic [NUM_ROW-1:0] row_en_s;
    logic               hit_s;
    logic               edge_s;
    logic [3:0]         hit_col_s;
    logic [3:0]         hit_row_s;

    // Edge detect against the previous-cycle flag; counts clamped to storage.
    assign trig_s    = project_done_flag & ~pdf_r;
    assign nc_s      = (num_col > 4'(NUM_COL)) ? 4'(NUM_COL) : num_col;
    assign nr_s      = (num_row > 4'(NUM_ROW)) ? 4'(NUM_ROW) : num_row;
    assign ovf_s     = (num_col > 4'(NUM_COL)) | (num_row > 4'(NUM_ROW));
    assign done_s    = (cnt_r == lim_s);
    assign addr_nx_s = ((cnt_r + 6'd2) <= lim_s) ? (cnt_r + 6'd2) : 6'd0;
    // Word arriving now belongs to the address presented last cycle (cnt_r).
    assign cap_idx_s = cnt_r - 6'd1;

    // Number of addresses to read in the current load phase.
    always_comb begin
        lim_s = 6'd0;
        case (state_r)
            LOAD_COL: lim_s = {1'b0, nc_r, 1'b0};
            LOAD_ROW: lim_s = {1'b0, nr_r, 1'b0};
            default:  lim_s = 6'd0;
        endcase
    end

    // Next-state logic and read-address sequencing.
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r;
        col_addr_nx_s = '0;
        row_addr_nx_s = '0;
        latch_s       = 1'b0;
        case (state_r)
            IDLE, ACTIVE: begin
                if (trig_s) begin
                    state_nx_s    = LOAD_COL;
                    cnt_nx_s      = 6'd0;
                    latch_s       = 1'b1;
                    col_addr_nx_s = (nc_s != 4'd0) ? DEPBIT'(1) : DEPBIT'(0);
                end else begin
                    state_nx_s = state_r;
                end
            end
            LOAD_COL: begin
                if (done_s) begin
                    state_nx_s    = LOAD_ROW;
                    cnt_nx_s      = 6'd0;
                    row_addr_nx_s = (nr_r != 4'd0) ? DEPBIT'(1) : DEPBIT'(0);
                end else begin
                    cnt_nx_s      = cnt_r + 6'd1;
                    col_addr_nx_s = DEPBIT'(addr_nx_s);
                end
            end
            LOAD_ROW: begin
                if (done_s) begin
                    state_nx_s = ACTIVE;
                    cnt_nx_s   = 6'd0;
                end else begin
                    cnt_nx_s      = cnt_r + 6'd1;
                    row_addr_nx_s = DEPBIT'(addr_nx_s);
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = 6'd0;
            end
        endcase
    end

    // FSM state, counters, latched counts and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r            <= IDLE;
            cnt_r              <= 6'd0;
            pdf_r              <= 1'b0;
            nc_r               <= 4'd0;
            nr_r               <= 4'd0;
            cnt_ovf            <= 1'b0;
            boxes_valid        <= 1'b0;
            load_busy          <= 1'b0;
            col_border_addr_rd <= '0;
            row_border_addr_rd <= '0;
        end else begin
            pdf_r              <= project_done_flag;
            state_r            <= state_nx_s;
            cnt_r              <= cnt_nx_s;
            col_border_addr_rd <= col_addr_nx_s;
            row_border_addr_rd <= row_addr_nx_s;
            boxes_valid        <= (state_nx_s == ACTIVE);
            load_busy          <= (state_nx_s == LOAD_COL) | (state_nx_s == LOAD_ROW);
            if (latch_s) begin
                nc_r    <= nc_s;
                nr_r    <= nr_s;
                cnt_ovf <= ovf_s;
            end
        end
    end

    // Capture returned border words into the box register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_COL; c++) begin
                left_r[c]  <= '0;
                right_r[c] <= '0;
            end
            for (int r = 0; r < NUM_ROW; r++) begin
                top_r[r]    <= '0;
                bottom_r[r] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_COL; c++) begin
                if ((state_r == LOAD_COL) && (cnt_r != 6'd0) && (cap_idx_s[5:1] == 5'(c))) begin
                    if (cap_idx_s[0]) right_r[c] <= col_border_data_rd;
                    else              left_r[c]  <= col_border_data_rd;
                end
            end
            for (int r = 0; r < NUM_ROW; r++) begin
                if ((state_r == LOAD_ROW) && (cnt_r != 6'd0) && (cap_idx_s[5:1] == 5'(r))) begin
                    if (cap_idx_s[0]) bottom_r[r] <= row_border_data_rd;
                    else              top_r[r]    <= row_border_data_rd;
                end
            end
        end
    end

    // Per-column and per-row enables: within latched count and not inverted.
    always_comb begin
        col_en_s = '0;
        row_en_s = '0;
        for (int c = 0; c < NUM_COL; c++) begin
            col_en_s[c] = (4'(c) < nc_r) && (left_r[c] <= right_r[c]);
        end
        for (int r = 0; r < NUM_ROW; r++) begin
            row_en_s[r] = (4'(r) < nr_r) && (top_r[r] <= bottom_r[r]);
        end
    end

    // Pixel hit search; scanning from the highest index down lets the
    // lowest row, then lowest column, overwrite and win.
    always_comb begin
        hit_s     = 1'b0;
        edge_s    = 1'b0;
        hit_col_s = 4'd0;
        hit_row_s = 4'd0;
        for (int r = NUM_ROW - 1; r >= 0; r--) begin
            for (int c = NUM_COL - 1; c >= 0; c--) begin
                if (col_en_s[c] && row_en_s[r] &&
                    (xpos >= 11'(left_r[c])) && (xpos <= 11'(right_r[c])) &&
                    (ypos >= 11'(top_r[r]))  && (ypos <= 11'(bottom_r[r]))) begin
                    hit_s     = 1'b1;
                    hit_col_s = 4'(c);
                    hit_row_s = 4'(r);
                    edge_s    = (xpos == 11'(left_r[c])) || (xpos == 11'(right_r[c])) ||
                                (ypos == 11'(top_r[r]))  || (ypos == 11'(bottom_r[r]));
                end else begin
                    hit_s = hit_s;
                end
            end
        end
    end

    // Classification is only live while settled in ACTIVE.
    assign cls_en_s = frame_de & boxes_valid & (state_r == ACTIVE) & (state_nx_s == ACTIVE);

    // Registered classification outputs, one cycle behind the pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_de      <= 1'b0;
            pix_in_box  <= 1'b0;
            pix_on_edge <= 1'b0;
            box_col_idx <= 4'd0;
            box_row_idx <= 4'd0;
        end else begin
            pix_de <= frame_de;
            if (cls_en_s && hit_s) begin
                pix_in_box  <= 1'b1;
                pix_on_edge <= edge_s;
                box_col_idx <= hit_col_s;
                box_row_idx <= hit_row_s;
            end else begin
                pix_in_box  <= 1'b0;
                pix_on_edge <= 1'b0;
                box_col_idx <= 4'd0;
                box_row_idx <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_digit_box_locator.sv
// Directed testbench for digit_box_locator with behavioural border RAMs.
module tb_digit_box_locator;

    logic        clk;
    logic        rst;
    logic        project_done_flag;
    logic [3:0]  num_col;
    logic [3:0]  num_row;
    logic [9:0]  col_border_addr_rd;
    logic [9:0]  col_border_data_rd;
    logic [9:0]  row_border_addr_rd;
    logic [9:0]  row_border_data_rd;
    logic        frame_de;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        boxes_valid;
    logic        load_busy;
    logic        cnt_ovf;
    logic        pix_de;
    logic        pix_in_box;
    logic        pix_on_edge;
    logic [3:0]  box_col_idx;
    logic [3:0]  box_row_idx;

    logic [9:0] col_mem [0:1023];
    logic [9:0] row_mem [0:1023];

    int tests;
    int fails;
    int busy_cnt;
    int max_addr;

    digit_box_locator #(.NUM_ROW(1), .NUM_COL(4), .DEPBIT(10)) dut (
        .clk                (clk),
        .rst                (rst),
        .project_done_flag  (project_done_flag),
        .num_col            (num_col),
        .num_row            (num_row),
        .col_border_addr_rd (col_border_addr_rd),
        .col_border_data_rd (col_border_data_rd),
        .row_border_addr_rd (row_border_addr_rd),
        .row_border_data_rd (row_border_data_rd),
        .frame_de           (frame_de),
        .xpos               (xpos),
        .ypos               (ypos),
        .boxes_valid        (boxes_valid),
        .load_busy          (load_busy),
        .cnt_ovf            (cnt_ovf),
        .pix_de             (pix_de),
        .pix_in_box         (pix_in_box),
        .pix_on_edge        (pix_on_edge),
        .box_col_idx        (box_col_idx),
        .box_row_idx        (box_row_idx)
    );

    always #5 clk = ~clk;

    // Synchronous-read border RAMs.
    always @(posedge clk) begin
        col_border_data_rd <= col_mem[col_border_addr_rd];
        row_border_data_rd <= row_mem[row_border_addr_rd];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic trigger;
        project_done_flag = 1'b0;
        tick();
        project_done_flag = 1'b1;
        tick();
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 64; i++) begin
            if (boxes_valid) break;
            tick();
        end
        check(tag, 32'(boxes_valid), 32'd1);
    endtask

    task automatic pix(input string tag, input int x, input int y,
                       input int e_hit, input int e_edge, input int e_col, input int e_row);
        xpos     = 11'(x);
        ypos     = 11'(y);
        frame_de = 1'b1;
        tick();
        frame_de = 1'b0;
        check({tag, ".de"},   32'(pix_de),      32'd1);
        check({tag, ".hit"},  32'(pix_in_box),  32'(e_hit));
        check({tag, ".edge"}, 32'(pix_on_edge), 32'(e_edge));
        check({tag, ".col"},  32'(box_col_idx), 32'(e_col));
        check({tag, ".row"},  32'(box_row_idx), 32'(e_row));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".valid"},   32'(boxes_valid),        32'd0);
        check({tag, ".busy"},    32'(load_busy),          32'd0);
        check({tag, ".ovf"},     32'(cnt_ovf),            32'd0);
        check({tag, ".caddr"},   32'(col_border_addr_rd), 32'd0);
        check({tag, ".raddr"},   32'(row_border_addr_rd), 32'd0);
        check({tag, ".inbox"},   32'(pix_in_box),         32'd0);
        check({tag, ".pixde"},   32'(pix_de),             32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clk = 1'b0;
        rst = 1'b1;
        project_done_flag = 1'b0;
        num_col = 4'd2;
        num_row = 4'd1;
        frame_de = 1'b0;
        xpos = 11'd0;
        ypos = 11'd0;
        for (int i = 0; i < 1024; i++) begin
            col_mem[i] = 10'd0;
            row_mem[i] = 10'd0;
        end
        col_mem[1] = 10'd40;  col_mem[2] = 10'd90;
        col_mem[3] = 10'd150; col_mem[4] = 10'd200;
        col_mem[5] = 10'd210; col_mem[6] = 10'd230;
        col_mem[7] = 10'd240; col_mem[8] = 10'd245;
        col_mem[9] = 10'd260; col_mem[10] = 10'd300;
        row_mem[1] = 10'd50;  row_mem[2] = 10'd120;

        // Reset state
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // 1: load sequence, nc=2, nr=1
        trigger();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t1.caddr%0d", k), 32'(col_border_addr_rd), (k < 4) ? 32'(k + 1) : 32'd0);
            check($sformatf("t1.raddr%0d", k), 32'(row_border_addr_rd),
                  (k == 5) ? 32'd1 : ((k == 6) ? 32'd2 : 32'd0));
            check($sformatf("t1.busy%0d", k),  32'(load_busy),   32'd1);
            check($sformatf("t1.valid%0d", k), 32'(boxes_valid), 32'd0);
            tick();
        end
        check("t1.valid_end", 32'(boxes_valid), 32'd1);
        check("t1.busy_end",  32'(load_busy),   32'd0);
        check("t1.ovf",       32'(cnt_ovf),     32'd0);

        // 2: classification, boxes col0=[40,90], col1=[150,200], row0=[50,120]
        pix("t2.in_col1",   160, 80, 1, 0, 1, 0);
        pix("t2.edge_l1",   150, 80, 1, 1, 1, 0);
        pix("t2.gap95",      95, 80, 0, 0, 0, 0);
        pix("t2.gap100",    100, 80, 0, 0, 0, 0);
        pix("t2.edge_l0",    40, 80, 1, 1, 0, 0);
        pix("t2.in_col0",    60, 80, 1, 0, 0, 0);
        pix("t2.edge_r1",   200, 80, 1, 1, 1, 0);
        pix("t2.out_r1",    201, 80, 0, 0, 0, 0);
        pix("t2.edge_bot",  160, 120, 1, 1, 1, 0);
        pix("t2.out_bot",   160, 121, 0, 0, 0, 0);
        pix("t2.out_top",   160, 49, 0, 0, 0, 0);
        xpos = 11'd160; ypos = 11'd80; frame_de = 1'b0;
        tick();
        check("t2.no_de.hit", 32'(pix_in_box), 32'd0);
        check("t2.no_de.de",  32'(pix_de),     32'd0);

        // 3: count overflow, only addresses 1..8 read
        num_col = 4'd6;
        trigger();
        max_addr = 0;
        for (int k = 0; k < 14; k++) begin
            if (int'(col_border_addr_rd) > max_addr) max_addr = int'(col_border_addr_rd);
            tick();
        end
        check("t3.max_addr", 32'(max_addr),    32'd8);
        check("t3.ovf",      32'(cnt_ovf),     32'd1);
        check("t3.valid",    32'(boxes_valid), 32'd1);
        pix("t3.col4_region", 280, 80, 0, 0, 0, 0);
        pix("t3.in_col2",     220, 80, 1, 0, 2, 0);
        pix("t3.edge_col3",   245, 100, 1, 1, 3, 0);

        // 4: inverted column 0
        col_mem[1] = 10'd1022;
        col_mem[2] = 10'd10;
        num_col = 4'd2;
        trigger();
        wait_valid("t4.valid");
        check("t4.ovf", 32'(cnt_ovf), 32'd0);
        pix("t4.c0_lo",    10, 80, 0, 0, 0, 0);
        pix("t4.c0_hi",  1022, 80, 0, 0, 0, 0);
        pix("t4.c0_mid",  500, 80, 0, 0, 0, 0);
        pix("t4.c1_edge", 150, 80, 1, 1, 1, 0);

        // 5: retrigger during load ignored; overlapping boxes col0=[60,160]
        col_mem[1] = 10'd60;
        col_mem[2] = 10'd160;
        trigger();
        busy_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 1) project_done_flag = 1'b0;
            if (i == 2) project_done_flag = 1'b1;
            busy_cnt += int'(load_busy);
            tick();
        end
        check("t5.busy_cycles", 32'(busy_cnt),    32'd8);
        check("t5.valid",       32'(boxes_valid), 32'd1);
        pix("t5.overlap_c0", 155, 80, 1, 0, 0, 0);
        pix("t5.c0_interior_at_c1_left", 150, 80, 1, 0, 0, 0);
        pix("t5.c1_only",    180, 80, 1, 0, 1, 0);
        pix("t5.c1_top",     180, 50, 1, 1, 1, 0);
        // reload while ACTIVE with new contents: col0=[60,100]
        col_mem[2] = 10'd100;
        trigger();
        check("t5.valid_drop", 32'(boxes_valid), 32'd0);
        check("t5.busy_rise",  32'(load_busy),   32'd1);
        wait_valid("t5.revalid");
        pix("t5.new_c1",     155, 80, 1, 0, 1, 0);
        pix("t5.new_c0edge", 100, 80, 1, 1, 0, 0);
        pix("t5.old_c0",     130, 80, 0, 0, 0, 0);

        // 6: asynchronous reset mid LOAD_ROW
        num_col = 4'd6;
        trigger();
        for (int k = 0; k < 10; k++) tick();
        check("t6.pre.busy",  32'(load_busy),          32'd1);
        check("t6.pre.ovf",   32'(cnt_ovf),            32'd1);
        check("t6.pre.raddr", 32'(row_border_addr_rd), 32'd2);
        #2;
        rst = 1'b1;
        project_done_flag = 1'b0;
        #1;
        check_idle_outputs("t6.async");
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t6.quiet_busy%0d", k),  32'(load_busy),   32'd0);
            check($sformatf("t6.quiet_valid%0d", k), 32'(boxes_valid), 32'd0);
        end
        pix("t6.no_boxes", 180, 80, 0, 0, 0, 0);

        // num_col = 0 load
        num_col = 4'd0;
        num_row = 4'd1;
        trigger();
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            busy_cnt += int'(load_busy);
            tick();
        end
        check("t6.nc0.busy_cycles", 32'(busy_cnt),    32'd4);
        check("t6.nc0.valid",       32'(boxes_valid), 32'd1);
        check("t6.nc0.ovf",         32'(cnt_ovf),     32'd0);
        pix("t6.nc0.p1", 180, 80, 0, 0, 0, 0);
        pix("t6.nc0.p2",  60, 80, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
